// File: rtl/sobel_window_gen.sv
// sobel_window_gen
// Streaming 3x3 window generator feeding the Sobel core. Raster-order
// pixels are accepted one per valid cycle; two line buffers supply the two
// previous lines at the same column. A 3x3 window register is shifted left
// on each accepted pixel. It is flagged valid only when the whole
// neighbourhood lies inside the frame.
//
// Ports
//   clk_i            sole clock, rising edge
//   rst_i            synchronous active-high reset
//   pixel_i          incoming grayscale pixel
//   pixel_valid_i    pixel_i accepted this cycle (no backpressure)
//   frame_start_i    with pixel_valid_i: this pixel is (row 0, col 0)
//   matrix_pixels_o  registered 3x3 window, flattened sobel_matrix:
//                    field (vector v, pix p) at bits [(v*3+p)*PIXEL_WIDTH +: PIXEL_WIDTH]
//                    vector0 = oldest line, vector2 = current line,
//                    pix0 = leftmost/oldest, pix2 = newest
//   matrix_valid_o   matrix_pixels_o holds a complete in-frame window
//   frame_done_o     pulse with the last window of a frame
module sobel_window_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 48
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [PIXEL_WIDTH-1:0]     pixel_i,
  input  logic                       pixel_valid_i,
  input  logic                       frame_start_i,
  output logic [9*PIXEL_WIDTH-1:0]   matrix_pixels_o,
  output logic                       matrix_valid_o,
  output logic                       frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;

  // [row][col][bit]; row 0 = oldest line, col 0 = oldest column
  logic [2:0][2:0][PIXEL_WIDTH-1:0] win_q, win_d;

  logic [PIXEL_WIDTH-1:0] lb0_q [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb0_d [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1_d [IMG_WIDTH];

  logic matrix_valid_q, matrix_valid_d;
  logic frame_done_q, frame_done_d;

  always_comb begin
    // A start-of-frame pixel is (0,0) whatever the counters say.
    col_eff        = frame_start_i ? '0 : col_q;
    row_eff        = frame_start_i ? '0 : row_q;
    col_d          = col_q;
    row_d          = row_q;
    win_d          = win_q;
    lb0_d          = lb0_q;
    lb1_d          = lb1_q;
    matrix_valid_d = 1'b0;
    frame_done_d   = 1'b0;

    if (pixel_valid_i) begin
      lb0_d[0] = pixel_i;
      lb1_d[0] = lb0_q[IMG_WIDTH-1];
      for (int i = 1; i < IMG_WIDTH; i++) begin
        lb0_d[i] = lb0_q[i-1];
        lb1_d[i] = lb1_q[i-1];
      end

      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_q[IMG_WIDTH-1];
      win_d[1][2] = lb0_q[IMG_WIDTH-1];
      win_d[2][2] = pixel_i;

      // Windows at c<2 straddle the line wrap and rows<2 reach above the
      // frame (stale line-buffer data); both are masked here.
      matrix_valid_d = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);

      if (col_eff == COL_LAST) begin
        col_d = '0;
        if (row_eff == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_eff + RW'(1);
        end
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q          <= '0;
      row_q          <= '0;
      win_q          <= '0;
      matrix_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      win_q          <= win_d;
      matrix_valid_q <= matrix_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Line buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk_i) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
  end

  assign matrix_pixels_o = win_q;
  assign matrix_valid_o  = matrix_valid_q;
  assign frame_done_o    = frame_done_q;

endmodule
